branch_update_demux: RTL and testbench
======================================

BRANCH_UPDATE_DEMUX -- requirements
Module: branch_update_demux

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8, number of predictor entries (power of 2, 2..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of buffered update slots (power of 2, 2..16).
REQ-003 SHALL have parameter CNT_W, default 8, width of each per-entry miss counter.
REQ-004 SHALL derive IDX_W = $clog2(NUM_ENTRIES) internally; it is not overridable.
REQ-005 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port UPD_VALID, input, 1, update request present.
REQ-008 SHALL have port UPD_READY, output, 1, the block can accept an update this cycle.
REQ-009 SHALL have port ADDR, input, 32, branch PC; index = ADDR[IDX_W+1:2].
REQ-010 SHALL have port OUTCOME, input, 1, resolved direction (1 = taken).
REQ-011 SHALL have port MISS, input, 1, the prediction was wrong.
REQ-012 SHALL have port STALL, input, 1, suspends draining.
REQ-013 SHALL have port FLUSH, input, 1, discards all buffered updates.
REQ-014 SHALL have port OUT_EN, output, NUM_ENTRIES, one-hot write strobe per entry.
REQ-015 SHALL have port OUT, output, NUM_ENTRIES, latched last outcome per entry.
REQ-016 SHALL have port MISS_OUT, output, NUM_ENTRIES, one-hot miss strobe.
REQ-017 SHALL have port MISS_CNT, output, NUM_ENTRIES*CNT_W, flattened per-entry miss counters; entry i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-018 SHALL push {index, OUTCOME, MISS} into the FIFO on any edge where UPD_VALID && UPD_READY.
REQ-019 SHALL drive UPD_READY = !full && !FLUSH; there is no same-cycle bypass of pop into a full FIFO.
REQ-020 SHALL pop one entry per cycle when the FIFO is non-empty, STALL=0 and FLUSH=0.
REQ-021 SHALL register the popped entry: OUT_EN[idx]=1 for exactly one cycle, OUT[idx]<=outcome, and MISS_OUT[idx]=miss for that same cycle. All other strobe bits SHALL be 0.
REQ-022 SHALL give a minimum latency of 2 edges from an accepted update to its strobe: push on edge N, pop on edge N+1, strobe visible after edge N+1.
REQ-023 SHALL preserve arrival order; two updates to the same index SHALL produce strobes on consecutive cycles, and the later outcome SHALL win.
REQ-024 SHALL let push and pop on the same edge leave the occupancy unchanged.
REQ-025 SHALL keep read and write pointers IDX-wide with an extra wrap bit; full = MSBs differ with the remaining bits equal, and empty = pointers equal.
REQ-026 SHALL, when FLUSH=1, clear both pointers on that edge, accept no push, issue no strobe, and leave OUT and MISS_CNT unchanged.
REQ-027 SHALL, when STALL=1, hold the FIFO contents, keep OUT_EN and MISS_OUT at 0, and still accept pushes while not full.

Reset
REQ-028 SHALL, while RESET_N=0, force FIFO empty and set UPD_READY=0, OUT_EN=0, OUT=0, MISS_OUT=0 and MISS_CNT=0, independent of CLK.
REQ-029 SHALL allow UPD_READY to rise on the first edge after RESET_N deasserts; updates in flight at reset are discarded.

Configuration
REQ-030 SHALL, with BRANCH_UPDATE_MISS_CNT_EN defined, increment MISS_CNT entry idx on every strobe with miss=1, saturating at 2^CNT_W-1 (no wrap).
REQ-031 SHALL, with BRANCH_UPDATE_MISS_CNT_EN undefined, tie MISS_CNT to 0 and synthesise no counter flops.

Structure
REQ-032 SHALL place the update-entry struct typedef and the pointer-width helper in the shared package branch_pred_pkg.
REQ-033 SHALL implement the FIFO as the sub-module branch_update_fifo (parameters DEPTH and W), instantiated once.

Verification
REQ-034 SHALL verify: reset, then one update ADDR=0x0000_0008, OUTCOME=1, MISS=1 -> after 2 edges OUT_EN=8'b0000_0100, OUT[2]=1, MISS_OUT[2]=1, MISS_CNT entry2=1.
REQ-035 SHALL verify: 5 back-to-back updates with STALL=1 and FIFO_DEPTH=4 -> UPD_READY=0 after 4 accepts; release STALL -> 4 strobes in order, then READY=1.
REQ-036 SHALL verify: FLUSH with 3 entries buffered -> no strobes, empty, OUT unchanged.
REQ-037 SHALL verify: 300 misses to index 1 with CNT_W=8 -> MISS_CNT entry1=255.
REQ-038 SHALL verify: RESET_N asserted mid-drain -> all outputs 0 immediately, no strobe after release.
REQ-039 SHALL verify: two updates to index 3 with outcomes 1 then 0 -> consecutive OUT_EN[3] pulses, final OUT[3]=0.

Source files
------------

// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the branch predictor update path.
// Holds the buffered update-entry layout and the FIFO pointer-width helper.
package branch_pred_pkg;

    // Index field is sized for the largest supported predictor (64 entries).
    localparam int MAX_IDX_W = 6;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] idx;
        logic                 outcome;
        logic                 miss;
    } upd_entry_t;

    localparam int UPD_ENTRY_W = $bits(upd_entry_t);

    // Pointer carries one extra wrap bit above the slot address.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/branch_update_fifo.sv
// Synchronous FIFO holding pending predictor updates; wrap-bit pointers give
// full/empty without a separate occupancy counter. Flush empties it in one edge.
module branch_update_fifo
    import branch_pred_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int AW    = PTR_W - 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // NOTE: storage is not reset; the pointers alone decide which slots are
    // valid, so the array stays a plain register file without reset fan-out.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/branch_update_demux.sv
// Buffers resolved-branch updates and fans each one out as a one-hot strobe
// to its predictor entry. Optional per-entry miss counters: BRANCH_UPDATE_MISS_CNT_EN.
module branch_update_demux
    import branch_pred_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         UPD_VALID,
    output logic                         UPD_READY,
    input  logic [31:0]                  ADDR,
    input  logic                         OUTCOME,
    input  logic                         MISS,
    input  logic                         STALL,
    input  logic                         FLUSH,
    output logic [NUM_ENTRIES-1:0]       OUT_EN,
    output logic [NUM_ENTRIES-1:0]       OUT,
    output logic [NUM_ENTRIES-1:0]       MISS_OUT,
    output logic [NUM_ENTRIES*CNT_W-1:0] MISS_CNT
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    upd_entry_t             w_wr_entry;
    upd_entry_t             w_rd_entry;
    logic [IDX_W-1:0]       w_rd_idx;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_unused;
    logic                   r_rst_done;
    logic [NUM_ENTRIES-1:0] r_out_en;
    logic [NUM_ENTRIES-1:0] r_out;
    logic [NUM_ENTRIES-1:0] r_miss_out;

    // NOTE: every field gets a default before the partial overrides so this
    // block can never infer a latch.
    always_comb begin
        w_wr_entry         = '0;
        w_wr_entry.idx     = MAX_IDX_W'(ADDR[IDX_W+1:2]);
        w_wr_entry.outcome = OUTCOME;
        w_wr_entry.miss    = MISS;
    end

    // Ready is held low until the first edge after reset release.
    assign UPD_READY = r_rst_done && !w_full && !FLUSH;
    assign w_push    = UPD_VALID && UPD_READY;
    assign w_pop     = !w_empty && !STALL && !FLUSH;
    assign w_rd_idx  = w_rd_entry.idx[IDX_W-1:0];

    branch_update_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UPD_ENTRY_W)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_push  (w_push),
        .i_wdata (w_wr_entry),
        .i_pop   (w_pop),
        .i_flush (FLUSH),
        .o_rdata (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rst_done <= 1'b0;
            r_out_en   <= '0;
            r_out      <= '0;
            r_miss_out <= '0;
        end else begin
            r_rst_done <= 1'b1;
            r_out_en   <= '0;
            r_miss_out <= '0;
            if (w_pop) begin
                r_out_en[w_rd_idx]   <= 1'b1;
                r_miss_out[w_rd_idx] <= w_rd_entry.miss;
                r_out[w_rd_idx]      <= w_rd_entry.outcome;
            end
        end
    end

    assign OUT_EN   = r_out_en;
    assign OUT      = r_out;
    assign MISS_OUT = r_miss_out;

`ifdef BRANCH_UPDATE_MISS_CNT_EN
    logic [CNT_W-1:0] r_miss_cnt [NUM_ENTRIES];

    // Counters saturate so a hot mispredicting branch never wraps to zero.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_miss_cnt[i] <= '0;
            end
        end else if (w_pop && w_rd_entry.miss &&
                     (r_miss_cnt[w_rd_idx] != {CNT_W{1'b1}})) begin
            r_miss_cnt[w_rd_idx] <= r_miss_cnt[w_rd_idx] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_cnt_flat
        assign MISS_CNT[g*CNT_W +: CNT_W] = r_miss_cnt[g];
    end
`else
    assign MISS_CNT = '0;
`endif

    // PC bits outside the index and the spare index bits are intentionally ignored.
    assign w_unused = ^{ADDR[31:IDX_W+2], ADDR[1:0], w_rd_entry.idx};

endmodule

// File: tb/tb_branch_update_demux.sv
// Directed bench for branch_update_demux: scoreboard of expected strobes,
// a small model of OUT and the miss counters, immediate-assertion checks.
module tb_branch_update_demux;

    localparam int NE      = 8;
    localparam int FD      = 4;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef BRANCH_UPDATE_MISS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] idx;
        logic       outcome;
        logic       miss;
    } exp_t;

    logic             CLK       = 1'b0;
    logic             RESET_N   = 1'b0;
    logic             UPD_VALID = 1'b0;
    logic             UPD_READY;
    logic [31:0]      ADDR      = '0;
    logic             OUTCOME   = 1'b0;
    logic             MISS      = 1'b0;
    logic             STALL     = 1'b0;
    logic             FLUSH     = 1'b0;
    logic [NE-1:0]    OUT_EN;
    logic [NE-1:0]    OUT;
    logic [NE-1:0]    MISS_OUT;
    logic [NE*CW-1:0] MISS_CNT;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    exp_t          mon_e;
    logic [NE-1:0] exp_out = '0;
    int            exp_cnt[NE];
    logic [NE-1:0] out_before;

    branch_update_demux #(
        .NUM_ENTRIES (NE),
        .FIFO_DEPTH  (FD),
        .CNT_W       (CW)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .UPD_VALID (UPD_VALID),
        .UPD_READY (UPD_READY),
        .ADDR      (ADDR),
        .OUTCOME   (OUTCOME),
        .MISS      (MISS),
        .STALL     (STALL),
        .FLUSH     (FLUSH),
        .OUT_EN    (OUT_EN),
        .OUT       (OUT),
        .MISS_OUT  (MISS_OUT),
        .MISS_CNT  (MISS_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NE*CW-1:0] cnt_vec();
        logic [NE*CW-1:0] v;
        v = '0;
        for (int i = 0; i < NE; i++) v[i*CW +: CW] = CW'(exp_cnt[i]);
        return v;
    endfunction

    // One update per call; returns 1ns after the edge that would accept it.
    task automatic send(input logic [31:0] a, input logic o, input logic m, input logic exp_acc);
        exp_t e;
        UPD_VALID = 1'b1;
        ADDR      = a;
        OUTCOME   = o;
        MISS      = m;
        @(negedge CLK);
        check("upd_ready", UPD_READY, exp_acc);
        @(posedge CLK);
        if (exp_acc) begin
            e.idx = a[4:2]; e.outcome = o; e.miss = m;
            sb.push_back(e);
        end
        #1;
        UPD_VALID = 1'b0;
    endtask

    // Output monitor: every strobe must match the oldest expected update.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (OUT_EN != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 64'(OUT_EN), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("strobe_en", 64'(OUT_EN), 64'd1 << mon_e.idx);
                    check("strobe_miss", 64'(MISS_OUT), mon_e.miss ? (64'd1 << mon_e.idx) : 64'd0);
                    exp_out[mon_e.idx] = mon_e.outcome;
                    if (CNT_EN && mon_e.miss && exp_cnt[mon_e.idx] < CNT_MAX)
                        exp_cnt[mon_e.idx]++;
                end
            end else begin
                check("idle_miss_out", 64'(MISS_OUT), 64'd0);
            end
            check("out_vec", 64'(OUT), 64'(exp_out));
            check("miss_cnt_vec", 64'(MISS_CNT), 64'(cnt_vec()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NE; i++) exp_cnt[i] = 0;

        // Reset state, before and during clocking.
        #2;
        check("rst_ready", UPD_READY, 1'b0);
        check("rst_out_en", 64'(OUT_EN), 64'd0);
        check("rst_out", 64'(OUT), 64'd0);
        check("rst_miss_out", 64'(MISS_OUT), 64'd0);
        check("rst_miss_cnt", 64'(MISS_CNT), 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready_clocked", UPD_READY, 1'b0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("ready_after_release", UPD_READY, 1'b1);
        @(posedge CLK); #1;

        // Single update to entry 2, two-edge latency.
        send(32'h0000_0008, 1'b1, 1'b1, 1'b1);
        @(negedge CLK);
        check("lat_no_early_strobe", 64'(OUT_EN), 64'd0);
        @(negedge CLK);
        check("single_out_en", 64'(OUT_EN), 64'b0000_0100);
        check("single_out2", OUT[2], 1'b1);
        check("single_miss_out", 64'(MISS_OUT), 64'b0000_0100);
        check("single_cnt2", 64'(MISS_CNT[2*CW +: CW]), CNT_EN ? 64'd1 : 64'd0);
        @(negedge CLK);
        check("single_strobe_one_cycle", 64'(OUT_EN), 64'd0);
        @(posedge CLK); #1;

        // Same index twice: consecutive pulses, later outcome wins.
        send(32'h0000_000C, 1'b1, 1'b0, 1'b1);
        send(32'h0000_000C, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        check("same_idx_first", 64'(OUT_EN), 64'b0000_1000);
        check("same_idx_first_out", OUT[3], 1'b1);
        @(negedge CLK);
        check("same_idx_second", 64'(OUT_EN), 64'b0000_1000);
        check("same_idx_final_out", OUT[3], 1'b0);
        @(posedge CLK); #1;

        // Fill under stall: four accepted, fifth refused, then ordered drain.
        STALL = 1'b1;
        send(32'h0000_0010, 1'b1, 1'b0, 1'b1);
        send(32'h0000_0014, 1'b0, 1'b1, 1'b1);
        send(32'h0000_0018, 1'b1, 1'b1, 1'b1);
        send(32'h0000_001C, 1'b1, 1'b0, 1'b1);
        send(32'h0000_0000, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        check("stall_no_strobe", 64'(OUT_EN), 64'd0);
        check("stall_full_ready", UPD_READY, 1'b0);
        @(posedge CLK); #1;
        STALL = 1'b0;
        @(negedge CLK);
        check("drain_not_yet", 64'(OUT_EN), 64'd0);
        for (int k = 4; k < 8; k++) begin
            @(negedge CLK);
            check("drain_order", 64'(OUT_EN), 64'd1 << k);
        end
        @(negedge CLK);
        check("drain_done", 64'(OUT_EN), 64'd0);
        check("drain_ready", UPD_READY, 1'b1);
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge CLK); #1;

        // Flush with three buffered entries.
        STALL = 1'b1;
        send(32'h0000_0008, 1'b0, 1'b1, 1'b1);
        send(32'h0000_000C, 1'b1, 1'b1, 1'b1);
        send(32'h0000_0014, 1'b1, 1'b1, 1'b1);
        out_before = exp_out;
        FLUSH = 1'b1;
        STALL = 1'b0;
        @(negedge CLK);
        check("flush_ready_low", UPD_READY, 1'b0);
        @(posedge CLK);
        sb.delete();
        #1;
        FLUSH = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("flush_no_strobe", 64'(OUT_EN), 64'd0);
        end
        check("flush_out_kept", 64'(OUT), 64'(out_before));
        check("flush_ready_back", UPD_READY, 1'b1);
        @(posedge CLK); #1;

        // Saturating miss counter on entry 1.
        for (int n = 0; n < 300; n++) send(32'h0000_0004, n[0], 1'b1, 1'b1);
        repeat (3) @(negedge CLK);
        check("sat_cnt1", 64'(MISS_CNT[1*CW +: CW]), CNT_EN ? 64'(CNT_MAX) : 64'd0);
        check("sat_cnt2_untouched", 64'(MISS_CNT[2*CW +: CW]), CNT_EN ? 64'd1 : 64'd0);
        @(posedge CLK); #1;

        // Reset in the middle of a drain.
        STALL = 1'b1;
        send(32'h0000_0010, 1'b0, 1'b1, 1'b1);
        send(32'h0000_0014, 1'b1, 1'b1, 1'b1);
        send(32'h0000_0018, 1'b0, 1'b1, 1'b1);
        STALL = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("mid_drain_strobe", 64'(OUT_EN), 64'b0001_0000);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_rst_out_en", 64'(OUT_EN), 64'd0);
        check("async_rst_out", 64'(OUT), 64'd0);
        check("async_rst_miss_out", 64'(MISS_OUT), 64'd0);
        check("async_rst_miss_cnt", 64'(MISS_CNT), 64'd0);
        check("async_rst_ready", UPD_READY, 1'b0);
        sb.delete();
        exp_out = '0;
        for (int i = 0; i < NE; i++) exp_cnt[i] = 0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            check("post_rst_no_strobe", 64'(OUT_EN), 64'd0);
        end
        check("post_rst_ready", UPD_READY, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
